bus_xfer_ctrl: RTL and testbench
================================

Name: bus_xfer_ctrl

Overview:
- Bus-master sequencer for the shared tri-state data bus. It is the initiator side of the OE/CS/EN/CNT_EN strobe protocol that register and counter slaves respond to.
- On a request it performs one transfer on the bus, source to destination; the source is a slave or an immediate value. Alternatively it issues a single count-increment pulse to one slave.
- Sits between the CPU control decoder and all bus slaves.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (8): bus width.
- NUM_DEV, 8: number of bus slaves.
- SEL_W, 3: width of the slave select field. Requires 2**SEL_W >= NUM_DEV.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  1  transfer/increment request; sampled only in IDLE
- op_inc  input  1  with req: 1 = increment dst_sel, 0 = bus transfer
- src_sel  input  SEL_W  source slave index; ignored when imm_en=1
- dst_sel  input  SEL_W  destination slave index
- imm_en  input  1  source is imm_data, driven by this block
- imm_data  input  DATA_WIDTH  immediate value
- busy  output  1  high in every state except IDLE
- ack  output  1  one-cycle completion pulse
- err  output  1  valid with ack; 1 = request rejected
- rd_data  output  DATA_WIDTH  bus value captured during the last transfer
- OE  output  NUM_DEV  per-slave output enable, one-hot or zero
- CS  output  NUM_DEV  per-slave chip select
- EN  output  NUM_DEV  per-slave load enable (level, latch-transparent)
- CNT_EN  output  NUM_DEV  per-slave count enable
- data  inout  DATA_WIDTH  shared bus; driven only while the IMM source is active, else Z

Behaviour:
- Reset (async, reset=0) forces:
  - state IDLE
  - busy, ack, err = 0
  - OE, CS, EN, CNT_EN = 0
  - rd_data = 0
  - data released to Z
- A reset mid-operation takes effect immediately, within the same cycle; the aborted transfer produces no ack.
- FSM states: IDLE, SETUP, LATCH, HOLD, INC, DONE. All outputs are registered and decoded from state plus latched request fields.
- IDLE: on an edge with req=1, latch op_inc, src_sel, dst_sel, imm_en and imm_data. Then:
  - Error case: dst_sel >= NUM_DEV, or (!imm_en && (src_sel >= NUM_DEV || src_sel == dst_sel)) → DONE with err=1; no strobes are ever asserted.
  - Else if op_inc → INC.
  - Else → SETUP.
- SETUP (1 cycle):
  - CS[src] = 1 and OE[src] = 1; or, for an immediate source, data is driven with the latched imm_data.
  - CS[dst] = 1, EN = 0.
  - Next state: LATCH.
- LATCH (1 cycle): same drive as SETUP, plus EN[dst] = 1. Next state: HOLD.
- HOLD (1 cycle):
  - EN = 0; the source stays driven so the latch closes on stable data.
  - rd_data captures data at the HOLD→DONE edge.
  - Next state: DONE.
- INC (1 cycle): CS[dst] = 1, CNT_EN[dst] = 1, EN = 0, OE = 0. The slave increments on the INC→DONE edge. Next state: DONE.
- DONE (1 cycle): all strobes 0, data = Z, ack = 1, err as decided in IDLE. Next state: IDLE.
- Latency, with req sampled at edge N:
  - Transfer: ack high during cycle N+4, busy high during N+1..N+4.
  - Increment: ack high during N+2.
  - Error: ack high during N+1.
- Request rules:
  - req is ignored while busy; no queueing.
  - A new request is accepted at the DONE→IDLE edge+1 at the earliest, i.e. a back-to-back transfer needs 5 cycles.
  - Request inputs may change once busy=1.
- Bus safety invariants:
  - At most one OE bit is set at any time.
  - OE is never set while this block drives data.
  - EN and CNT_EN are never set to the same slave in the same cycle.
  - EN is never high in SETUP or HOLD.
- No arithmetic. Select indices are compared unsigned. The count wrap-around is the slave's own behaviour; this block only pulses CNT_EN.

Test Plan:
1. Reset low while in LATCH with src=2, dst=5 → OE, CS, EN = 0 and data = Z immediately; no ack. After release, busy = 0.
2. imm_en=1, imm_data=0xA5, dst=3, req at edge N → EN[3] high only in cycle N+2; data = 0xA5 during N+1..N+3; ack=1 and err=0 in N+4; rd_data = 0xA5.
3. Slave 1 holds 0x3C; src=1, dst=4 → OE[1] and CS[1] high in N+1..N+3, EN[4] high in N+2 only; rd_data = 0x3C; data never driven by the controller.
4. op_inc=1, dst=0, with slave 0 at 0xFF → CNT_EN[0] high for exactly one cycle (N+1); ack in N+2. The slave wraps to 0x00.
5. src=dst=2 → ack=1 and err=1 in N+1; no strobe asserted at any point. Then dst_sel=7 with NUM_DEV=6 → same error response.
6. req held high continuously, plus a second request asserted mid-transfer → mid-transfer request ignored. Transfers complete every 5 cycles; the one-hot OE assertion holds throughout.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: bus-master sequencer driving the OE/CS/EN/CNT_EN strobe protocol
// for one transfer (slave or immediate source) or one count-increment pulse per request.
`default_nettype none

module bus_xfer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DEV    = 8,
  parameter int SEL_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  op_inc,
  input  logic [SEL_W-1:0]      src_sel,
  input  logic [SEL_W-1:0]      dst_sel,
  input  logic                  imm_en,
  input  logic [DATA_WIDTH-1:0] imm_data,
  output logic                  busy,
  output logic                  ack,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [NUM_DEV-1:0]    OE,
  output logic [NUM_DEV-1:0]    CS,
  output logic [NUM_DEV-1:0]    EN,
  output logic [NUM_DEV-1:0]    CNT_EN,
  inout  wire  [DATA_WIDTH-1:0] data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_INC   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            r_state, w_next_state;
  logic                  r_op_inc, w_op_inc;
  logic [SEL_W-1:0]      r_src, w_src;
  logic [SEL_W-1:0]      r_dst, w_dst;
  logic                  r_imm_en, w_imm_en;
  logic [DATA_WIDTH-1:0] r_imm_data, w_imm_data;
  logic                  r_err, w_err;
  logic                  w_reject;

  logic                  r_busy, w_busy;
  logic                  r_ack, w_ack;
  logic                  r_drive, w_drive;
  logic [NUM_DEV-1:0]    r_oe, w_oe;
  logic [NUM_DEV-1:0]    r_cs, w_cs;
  logic [NUM_DEV-1:0]    r_en, w_en;
  logic [NUM_DEV-1:0]    r_cnt_en, w_cnt_en;
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Out-of-range selects decode to all-zero, so no strobe can ever reach a missing slave.
  function automatic logic [NUM_DEV-1:0] f_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_DEV-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      v[i] = (32'(sel) == i);
    end
    return v;
  endfunction

  assign w_reject = (32'(dst_sel) >= NUM_DEV) ||
                    (!imm_en && ((32'(src_sel) >= NUM_DEV) || (src_sel == dst_sel)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_op_inc   <= 1'b0;
      r_src      <= '0;
      r_dst      <= '0;
      r_imm_en   <= 1'b0;
      r_imm_data <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_drive    <= 1'b0;
      r_oe       <= '0;
      r_cs       <= '0;
      r_en       <= '0;
      r_cnt_en   <= '0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_op_inc   <= w_op_inc;
      r_src      <= w_src;
      r_dst      <= w_dst;
      r_imm_en   <= w_imm_en;
      r_imm_data <= w_imm_data;
      r_err      <= w_err;
      r_busy     <= w_busy;
      r_ack      <= w_ack;
      r_drive    <= w_drive;
      r_oe       <= w_oe;
      r_cs       <= w_cs;
      r_en       <= w_en;
      r_cnt_en   <= w_cnt_en;
      if (r_state == S_HOLD) begin
        r_rd_data <= data;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_op_inc     = r_op_inc;
    w_src        = r_src;
    w_dst        = r_dst;
    w_imm_en     = r_imm_en;
    w_imm_data   = r_imm_data;
    w_err        = r_err;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_op_inc   = op_inc;
          w_src      = src_sel;
          w_dst      = dst_sel;
          w_imm_en   = imm_en;
          w_imm_data = imm_data;
          w_err      = w_reject;
          if (w_reject)    w_next_state = S_DONE;
          else if (op_inc) w_next_state = S_INC;
          else             w_next_state = S_SETUP;
        end
      end
      S_SETUP: w_next_state = S_LATCH;
      S_LATCH: w_next_state = S_HOLD;
      S_HOLD:  w_next_state = S_DONE;
      S_INC:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    w_busy   = (w_next_state != S_IDLE);
    w_ack    = 1'b0;
    w_drive  = 1'b0;
    w_oe     = '0;
    w_cs     = '0;
    w_en     = '0;
    w_cnt_en = '0;
    case (w_next_state)
      S_SETUP, S_LATCH, S_HOLD: begin
        if (w_imm_en) begin
          w_drive = 1'b1;
        end else begin
          w_oe = f_onehot(w_src);
        end
        w_cs = w_oe | f_onehot(w_dst);
        if (w_next_state == S_LATCH) begin
          w_en = f_onehot(w_dst);
        end
      end
      S_INC: begin
        w_cs     = f_onehot(w_dst);
        w_cnt_en = f_onehot(w_dst);
      end
      S_DONE:  w_ack = 1'b1;
      default: ;
    endcase
  end

  assign busy    = r_busy;
  assign ack     = r_ack;
  assign err     = r_ack & r_err;
  assign rd_data = r_rd_data;
  assign OE      = r_oe;
  assign CS      = r_cs;
  assign EN      = r_en;
  assign CNT_EN  = r_cnt_en;
  assign data    = r_drive ? r_imm_data : {DATA_WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: bus slave models plus a transaction-level reference for bus_xfer_ctrl.
`default_nettype none

module tb_bus_xfer_ctrl;

  localparam int DW  = 8;
  localparam int ND  = 6;
  localparam int SW  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, op_inc, imm_en;
  logic [SW-1:0] src_sel, dst_sel;
  logic [DW-1:0] imm_data;
  logic          busy, ack, err;
  logic [DW-1:0] rd_data;
  logic [ND-1:0] OE, CS, EN, CNT_EN;
  wire  [DW-1:0] data;

  int checks = 0;
  int errors = 0;
  int inv_err = 0;

  logic [DW-1:0] sreg [ND];
  logic          slave_drv;
  logic [DW-1:0] slave_val;

  bus_xfer_ctrl #(.DATA_WIDTH(DW), .NUM_DEV(ND), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .req(req), .op_inc(op_inc),
    .src_sel(src_sel), .dst_sel(dst_sel), .imm_en(imm_en), .imm_data(imm_data),
    .busy(busy), .ack(ack), .err(err), .rd_data(rd_data),
    .OE(OE), .CS(CS), .EN(EN), .CNT_EN(CNT_EN), .data(data)
  );

  always #5 clk = ~clk;

  always_comb begin
    slave_drv = 1'b0;
    slave_val = '0;
    for (int i = 0; i < ND; i++) begin
      if (OE[i]) begin
        slave_drv = 1'b1;
        slave_val = sreg[i];
      end
    end
  end
  assign data = slave_drv ? slave_val : {DW{1'bz}};

  // Slaves: transparent latch on EN, counter step on CNT_EN; bus invariants watched every cycle.
  always @(negedge clk) begin
    if (reset) begin
      if ($countones(OE) > 1) inv_err++;
      if (|(EN & CNT_EN)) inv_err++;
    end
    for (int i = 0; i < ND; i++) begin
      if (EN[i]) sreg[i] <= data;
      else if (CNT_EN[i]) sreg[i] <= sreg[i] + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ND-1:0] oh(input logic [SW-1:0] s);
    return (int'(s) < ND) ? (ND'(1) << s) : '0;
  endfunction

  task automatic drive_noise();
    req      = 1'($urandom);
    op_inc   = 1'($urandom);
    src_sel  = SW'($urandom);
    dst_sel  = SW'($urandom);
    imm_en   = 1'($urandom);
    imm_data = DW'($urandom);
  endtask

  // Called just after a negedge with the controller idle; issues one request and checks every cycle.
  task automatic run_req(input logic op, input logic [SW-1:0] src, input logic [SW-1:0] dst,
                         input logic imm, input logic [DW-1:0] immd, input bit noise);
    logic          rej;
    int            len;
    logic [DW-1:0] exp_val;
    logic [ND-1:0] e_oe, e_cs, e_en, e_cnt;
    rej = (int'(dst) >= ND) || (!imm && ((int'(src) >= ND) || (src == dst)));
    len = rej ? 1 : (op ? 2 : 4);
    exp_val = '0;
    if (!rej) exp_val = op ? (sreg[dst] + 8'd1) : (imm ? immd : sreg[src]);
    req = 1'b1; op_inc = op; src_sel = src; dst_sel = dst; imm_en = imm; imm_data = immd;
    @(posedge clk);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      e_oe = '0; e_cs = '0; e_en = '0; e_cnt = '0;
      if (!rej && !op && k <= 3) begin
        e_oe = imm ? '0 : oh(src);
        e_cs = e_oe | oh(dst);
        e_en = (k == 2) ? oh(dst) : '0;
      end
      if (!rej && op && k == 1) begin
        e_cs  = oh(dst);
        e_cnt = oh(dst);
      end
      chk("busy", 64'(busy), 64'd1);
      chk("strobes", 64'({OE, CS, EN, CNT_EN}), 64'({e_oe, e_cs, e_en, e_cnt}));
      chk("ack_err", 64'({ack, err}), 64'({k == len, (k == len) && rej}));
      if (!rej && !op && k <= 3) chk("bus_data", 64'(data), 64'(exp_val));
      if (!rej && !op && k == 4) chk("rd_data", 64'(rd_data), 64'(exp_val));
      if (noise && k < len) drive_noise();
      else req = 1'b0;
    end
    @(negedge clk);
    chk("idle_busy_ack", 64'({busy, ack}), 64'd0);
    chk("idle_strobes", 64'({OE, CS, EN, CNT_EN}), 64'd0);
    if (!rej) chk("slave_result", 64'(sreg[dst]), 64'(exp_val));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int      ack_seen;
    int      oe_bad;
    logic [31:0] ack_mask, exp_mask;
    reset = 1'b0; req = 1'b0; op_inc = 1'b0; src_sel = '0; dst_sel = '0;
    imm_en = 1'b0; imm_data = '0;
    for (int i = 0; i < ND; i++) sreg[i] = DW'($urandom);
    sreg[0] = 8'hFF;
    sreg[1] = 8'h3C;
    repeat (3) @(negedge clk);
    chk("rst_flags", 64'({busy, ack, err}), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_strobes", 64'({OE, CS, EN, CNT_EN}), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_req(1'b0, 3'd0, 3'd3, 1'b1, 8'hA5, 1'b0);
    run_req(1'b0, 3'd1, 3'd4, 1'b0, 8'h00, 1'b0);
    run_req(1'b1, 3'd5, 3'd0, 1'b0, 8'h00, 1'b0);
    chk("inc_wrap", 64'(sreg[0]), 64'h00);
    run_req(1'b0, 3'd2, 3'd2, 1'b0, 8'h00, 1'b0);
    run_req(1'b0, 3'd0, 3'd7, 1'b1, 8'h11, 1'b0);

    // Reset asserted in the middle of the LATCH cycle.
    req = 1'b1; op_inc = 1'b0; src_sel = 3'd2; dst_sel = 3'd5; imm_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("latch_en", 64'(EN), 64'(oh(3'd5)));
    #2 reset = 1'b0;
    #1;
    chk("async_rst_strobes", 64'({OE, CS, EN, CNT_EN}), 64'd0);
    chk("async_rst_flags", 64'({busy, ack}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ack_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack || busy) ack_seen++;
    end
    chk("post_rst_quiet", 64'(ack_seen), 64'd0);

    // Request held high: one transfer every 5 cycles, nothing queued.
    req = 1'b1; op_inc = 1'b0; src_sel = 3'd3; dst_sel = 3'd1; imm_en = 1'b0;
    ack_mask = '0; exp_mask = '0; oe_bad = 0;
    @(posedge clk);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k % 5 == 4) exp_mask[k] = 1'b1;
      ack_mask[k] = ack;
      if (OE != '0 && OE != oh(3'd3)) oe_bad++;
      if (k == 25) req = 1'b0;
    end
    chk("b2b_ack_timing", 64'(ack_mask), 64'(exp_mask));
    chk("b2b_oe", 64'(oe_bad), 64'd0);
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      run_req(1'($urandom_range(0, 3) == 0), SW'($urandom), SW'($urandom),
              1'($urandom), DW'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    chk("bus_invariants", 64'(inv_err), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
